// File: rtl/wb_arbiter_if.sv
// Writeback bus between EX/accelerator completion paths, the arbiter and the regfile.
interface wb_arbiter_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 3
);
  logic                   alu_valid;
  logic [ADDR_W-1:0]      alu_rd;
  logic [DATA_W-1:0]      alu_data;
  logic                   acc_valid;
  logic                   acc_ready;
  logic [ADDR_W-1:0]      acc_rd;
  logic [DATA_W-1:0]      acc_data;
  logic                   pend_set;
  logic [ADDR_W-1:0]      pend_addr;
  logic [2**ADDR_W-1:0]   pending;
  logic                   stall_req;
  logic                   reg_write;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_W-1:0]      wb_data;

  modport master (
    output alu_valid, alu_rd, alu_data, acc_valid, acc_rd, acc_data, pend_set, pend_addr,
    input  acc_ready, pending, stall_req, reg_write, rd_addr, wb_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, acc_valid, acc_rd, acc_data, pend_set, pend_addr,
    output acc_ready, pending, stall_req, reg_write, rd_addr, wb_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU-priority merge with accelerator result FIFO, starvation stall and
// optional pending-write scoreboard (enabled by defining WB_SCOREBOARD_EN).
module wb_arbiter #(
  parameter int DATA_W       = 19,
  parameter int ADDR_W       = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int NREG  = 2**ADDR_W;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef logic [PTR_W:0] ptr_t;

  logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_rd_d   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  logic [3:0]        starve_q, starve_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic              empty, full, push, pop;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  // Full/empty from extra-MSB pointers; acc_ready ignores a same-cycle pop.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    push      = bus.acc_valid && !full;
    pop       = !bus.alu_valid && !empty;
    head_rd   = fifo_rd_q[rd_ptr_q[PTR_W-1:0]];
    head_data = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q[PTR_W-1:0]]   = bus.acc_rd;
      fifo_data_d[wr_ptr_q[PTR_W-1:0]] = bus.acc_data;
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_comb begin
    reg_write_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    wb_data_d   = wb_data_q;
    if (bus.alu_valid) begin
      reg_write_d = 1'b1;
      rd_addr_d   = bus.alu_rd;
      wb_data_d   = bus.alu_data;
    end else if (pop) begin
      reg_write_d = 1'b1;
      rd_addr_d   = head_rd;
      wb_data_d   = head_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (bus.alu_valid && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

`ifdef WB_SCOREBOARD_EN
  // Set is applied after clear so a younger issue to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_rd] = 1'b0;
    end
    if (bus.pend_set) begin
      pending_d[bus.pend_addr] = 1'b1;
    end
  end
`else
  logic unused_pend;
  assign unused_pend = ^{bus.pend_set, bus.pend_addr, pending_q};
  assign pending_d   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_q   <= '{default: '0};
      fifo_data_q <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      starve_q    <= '0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      wb_data_q   <= '0;
      pending_q   <= '0;
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      starve_q    <= starve_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      wb_data_q   <= wb_data_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.acc_ready = !full;
  assign bus.stall_req = (starve_q == STARVE_MAX);
  assign bus.reg_write = reg_write_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wb_data   = wb_data_q;
`ifdef WB_SCOREBOARD_EN
  assign bus.pending   = pending_q;
`else
  assign bus.pending   = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model plus directed literal checks.
module tb_wb_arbiter;
  localparam int DW    = 19;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
`ifdef WB_SCOREBOARD_EN
  localparam logic SB_EN = 1'b1;
`else
  localparam logic SB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending accelerator results, abstract counters.
  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ent_t;
  ent_t           q[$];
  logic           m_we = 1'b0;
  logic [AW-1:0]  m_rd = '0;
  logic [DW-1:0]  m_data = '0;
  logic [7:0]     m_pend = '0;
  int             m_starve = 0;
  bit             m_push, m_pop;
  ent_t           m_head, m_new;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_we = 1'b0; m_rd = '0; m_data = '0; m_pend = '0; m_starve = 0;
      end else begin
        m_push = bus.acc_valid && (q.size() < DEPTH);
        m_pop  = !bus.alu_valid && (q.size() > 0);
        if (bus.alu_valid) begin
          m_we = 1'b1; m_rd = bus.alu_rd; m_data = bus.alu_data;
        end else if (m_pop) begin
          m_head = q[0];
          m_we = 1'b1; m_rd = m_head.rd; m_data = m_head.data;
        end else begin
          m_we = 1'b0;
        end
        if (q.size() == 0 || m_pop) m_starve = 0;
        else if (bus.alu_valid && m_starve < LIMIT) m_starve++;
        if (m_pop) begin
          m_pend[q[0].rd] = 1'b0;
          void'(q.pop_front());
        end
        if (bus.pend_set) m_pend[bus.pend_addr] = 1'b1;
        if (m_push) begin
          m_new.rd = bus.acc_rd; m_new.data = bus.acc_data;
          q.push_back(m_new);
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_reg_write", 32'(bus.reg_write), 32'(m_we));
        if (m_we) begin
          check("m_rd_addr", 32'(bus.rd_addr), 32'(m_rd));
          check("m_wb_data", 32'(bus.wb_data), 32'(m_data));
        end
        check("m_acc_ready", 32'(bus.acc_ready), 32'(q.size() < DEPTH));
        check("m_stall_req", 32'(bus.stall_req), 32'(m_starve == LIMIT));
        check("m_pending", 32'(bus.pending), SB_EN ? 32'(m_pend) : 32'd0);
      end
    end
  end

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.acc_valid = 1'b0; bus.acc_rd = '0; bus.acc_data = '0;
    bus.pend_set  = 1'b0; bus.pend_addr = '0;
  endtask

  initial begin
    idle();
    // Reset held with ALU traffic present
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd6; bus.alu_data = 19'd99;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_reg_write", 32'(bus.reg_write), 32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_wb_data", 32'(bus.wb_data), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'h00);
    check("rst_acc_ready", 32'(bus.acc_ready), 32'd1);
    check("rst_stall", 32'(bus.stall_req), 32'd0);
    rst_n = 1'b1;
    bus.alu_rd = 3'd1; bus.alu_data = 19'd123;
    @(negedge clk);
    check("alu_we", 32'(bus.reg_write), 32'd1);
    check("alu_rd", 32'(bus.rd_addr), 32'd1);
    check("alu_data", 32'(bus.wb_data), 32'd123);

    // Contention
    bus.alu_rd = 3'd2; bus.alu_data = 19'd5;
    bus.acc_valid = 1'b1; bus.acc_rd = 3'd3; bus.acc_data = 19'd7;
    @(negedge clk);
    idle();
    check("cont1_rd", 32'(bus.rd_addr), 32'd2);
    check("cont1_data", 32'(bus.wb_data), 32'd5);
    @(negedge clk);
    check("cont2_we", 32'(bus.reg_write), 32'd1);
    check("cont2_rd", 32'(bus.rd_addr), 32'd3);
    check("cont2_data", 32'(bus.wb_data), 32'd7);

    // Fill FIFO under continuous ALU traffic, then starvation
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd0; bus.alu_data = 19'd1;
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 32'(bus.acc_ready), 32'd1);
      bus.acc_valid = 1'b1; bus.acc_rd = 3'(4 + i); bus.acc_data = 19'(10 + i);
      @(negedge clk);
    end
    check("full_ready", 32'(bus.acc_ready), 32'd0);
    check("starve_stall", 32'(bus.stall_req), 32'd1);
    idle();
    @(negedge clk);
    check("drain_we", 32'(bus.reg_write), 32'd1);
    check("drain_rd", 32'(bus.rd_addr), 32'd4);
    check("drain_data", 32'(bus.wb_data), 32'd10);
    check("drain_stall", 32'(bus.stall_req), 32'd0);
    repeat (4) @(negedge clk);

    // Scoreboard
    bus.pend_set = 1'b1; bus.pend_addr = 3'd5;
    @(negedge clk);
    idle();
    check("sb_set", 32'(bus.pending[5]), 32'(SB_EN));
    bus.acc_valid = 1'b1; bus.acc_rd = 3'd5; bus.acc_data = 19'd20;
    @(negedge clk);
    idle();
    check("sb_queued", 32'(bus.pending[5]), 32'(SB_EN));
    @(negedge clk);
    check("sb_pop_we", 32'(bus.reg_write), 32'd1);
    check("sb_pop_rd", 32'(bus.rd_addr), 32'd5);
    check("sb_cleared", 32'(bus.pending[5]), 32'd0);
    bus.acc_valid = 1'b1; bus.acc_rd = 3'd5; bus.acc_data = 19'd21;
    bus.pend_set = 1'b1; bus.pend_addr = 3'd5;
    @(negedge clk);
    idle();
    bus.pend_set = 1'b1; bus.pend_addr = 3'd5;
    @(negedge clk);
    idle();
    check("sb_race_data", 32'(bus.wb_data), 32'd21);
    check("sb_set_wins", 32'(bus.pending[5]), 32'(SB_EN));
    @(negedge clk);

    // Async reset with entries queued
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd0; bus.alu_data = 19'd2;
    for (int i = 0; i < 3; i++) begin
      bus.acc_valid = 1'b1; bus.acc_rd = 3'(1 + i); bus.acc_data = 19'(40 + i);
      bus.pend_set = 1'b1; bus.pend_addr = 3'(1 + i);
      @(negedge clk);
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(bus.reg_write), 32'd0);
    check("arst_pending", 32'(bus.pending), 32'd0);
    check("arst_ready", 32'(bus.acc_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("arst_nowrite", 32'(bus.reg_write), 32'd0);
    end

    // Randomized traffic, honouring stall_req upstream
    for (int i = 0; i < 3000; i++) begin
      bus.alu_valid = bus.stall_req ? 1'b0 : ($urandom_range(0, 99) < 60);
      bus.alu_rd    = 3'($urandom);
      bus.alu_data  = 19'($urandom);
      bus.acc_valid = ($urandom_range(0, 99) < 50);
      bus.acc_rd    = 3'($urandom);
      bus.acc_data  = 19'($urandom);
      bus.pend_set  = ($urandom_range(0, 99) < 30);
      bus.pend_addr = 3'($urandom);
      @(negedge clk);
    end
    idle();
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and scoreboard that drives the single write port of the 8×19-bit register file. It merges in-order ALU results with out-of-order results from the FFT/crypto accelerators, buffering the accelerator results in a small FIFO. It also tracks which destination registers have an accelerator write still outstanding. It sits between the EX/accelerator completion paths and the regfile `rd_addr`/`wb_data`/`reg_write` inputs.

## Interface
Parameters:
- `DATA_W`, 19: register data width.
- `ADDR_W`, 3: register address width; the register count is 2**ADDR_W.
- `FIFO_DEPTH`, 4: accelerator result FIFO depth; must be a power of two, ≥2.
- `STARVE_LIMIT`, 3: consecutive blocked cycles before `stall_req` asserts; range 1..15.

Ports:
- Clocking: one clock, `clk`. Reset is `rst_n`, asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `alu_valid` in 1: ALU result valid this cycle. This path has no backpressure.
- `alu_rd` in ADDR_W: ALU destination register.
- `alu_data` in DATA_W: ALU result.
- `acc_valid` in 1: accelerator result offered.
- `acc_ready` out 1: FIFO can accept; equals !full.
- `acc_rd` in ADDR_W: accelerator destination register.
- `acc_data` in DATA_W: accelerator result.
- `pend_set` in 1: an accelerator op was issued; marks `pend_addr` as pending.
- `pend_addr` in ADDR_W: destination register of the issued accelerator op.
- `pending` out 2**ADDR_W: per-register outstanding-accelerator-write bits.
- `stall_req` out 1: asks the pipeline to insert one ALU bubble.
- `reg_write` out 1: regfile write enable (registered).
- `rd_addr` out ADDR_W: regfile write address (registered).
- `wb_data` out DATA_W: regfile write data (registered).

## Operation
- Priority each cycle: `alu_valid` wins. If `alu_valid` is 0 and the FIFO is non-empty, the arbiter pops the FIFO head and writes it.
- Accelerator push occurs when `acc_valid && acc_ready`.
- `acc_ready` is derived from the current full flag only. A pop in the same cycle does not open a slot for that cycle's push.
- Push and pop in the same cycle (FIFO not full) keep the count unchanged, and both take effect.
- The FIFO uses wrap-around pointers with one extra bit each. Full means the pointers differ only in the MSB; empty means the pointers are equal.
- Starvation counter `starve_cnt`:
  - Increments when the FIFO is non-empty and `alu_valid` is 1.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- `stall_req` = (`starve_cnt` == `STARVE_LIMIT`), combinational from the register. The upstream pipeline must drop `alu_valid` the next cycle.
- Scoreboard:
  - `pend_set` sets `pending[pend_addr]`.
  - A FIFO pop clears `pending[head.rd]`.
  - If a set and a clear hit the same address in the same cycle, set wins, because the new op is younger.
  - ALU writes never touch `pending`.
- No register address is special. Writes to address 0 pass through unchanged.

## Timing
- Reset (async assert, sync-style release on the next edge): `reg_write`=0, `rd_addr`=0, `wb_data`=0, `pending`=0, `stall_req`=0. The FIFO is empty, so `acc_ready`=1.
- ALU latency: `alu_valid` at edge N produces `reg_write`=1 with matching addr/data during cycle N+1. This is exactly one cycle.
- Accelerator latency when the FIFO is empty and there is no ALU traffic: push at edge N, then pop and write at edge N+1, so the write is visible during cycle N+2.
- `reg_write` is a single-cycle pulse per committed result. Back-to-back writes are allowed every cycle.
- Throughput: one write per cycle in total. A FIFO of depth `FIFO_DEPTH` absorbs `FIFO_DEPTH` accelerator results during an ALU burst.
- Reset asserted mid-operation: the FIFO contents are discarded, pointers reset to zero, and `pending` clears. Nothing is written after release until new input arrives.

## Configuration
- `WB_SCOREBOARD_EN`:
  - Defined: the `pending` register and its set/clear logic are present, as described above.
  - Undefined: `pending` is tied to all zeros and `pend_set`/`pend_addr` are ignored. Arbitration, FIFO and starvation behaviour are unchanged.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `alu_valid`=1 → `reg_write`=0, `pending`=0x00, `acc_ready`=1. After release, `alu_rd`=1 and `alu_data`=123 → next cycle `rd_addr`=1, `wb_data`=123, `reg_write`=1.
- Contention: `alu_valid` with rd=2, data=5 and `acc_valid` with rd=3, data=7 in the same cycle → cycle+1 writes r2=5, cycle+2 writes r3=7.
- FIFO full: hold `alu_valid`=1 and push 4 accelerator results, rd 4..7 with data 10..13 → `acc_ready`=0 after the 4th push.
- Starvation: continue the full-FIFO case with `alu_valid` held and `STARVE_LIMIT`=3 → `stall_req`=1 on the 3rd blocked cycle. Drop `alu_valid` → the arbiter writes r4=10 and `stall_req` goes to 0.
- Scoreboard: `pend_set` on address 5, then accelerator result rd=5 → `pending[5]`=1 until the write cycle, then 0. A `pend_set` on 5 in the same cycle as the pop → `pending[5]` stays 1.
- Async reset: assert reset with 3 entries queued → FIFO empties, `pending`=0, and no writes occur after release.
